// File: rtl/scr_base_l3_bk_snp_tx.sv
`default_nettype none
// ============================================================================
// Module   : scr_base_l3_bk_snp_tx
// Brief    : L3 bank snoop transmitter. Buffers snoop requests in a small
//            FIFO and sends each as one packed flit when a link credit is
//            held. An enable/drain FSM lets the link be quiesced cleanly.
//            Optional macro SCR_L3_SNP_TX_PERF_EN adds a credit-stall
//            counter output (snp_stall_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
module scr_base_l3_bk_snp_tx #(
    parameter int SCRID_W   = 4,
    parameter int TXNID_W   = 8,
    parameter int OPC_W     = 4,
    parameter int SIZE_W    = 3,
    parameter int ADDR_W    = 40,
    parameter int QUE_DEPTH = 4,
    parameter int CRDT_MAX  = 8,
    localparam int FLIT_W   = SCRID_W + TXNID_W + OPC_W + SIZE_W + ADDR_W,
    localparam int CNT_W    = $clog2(CRDT_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                snp_tx_en_i,
    input  logic                snp_req_val_i,
    input  logic [SCRID_W-1:0]  snp_req_scrid_i,
    input  logic [TXNID_W-1:0]  snp_req_txnid_i,
    input  logic [OPC_W-1:0]    snp_req_opc_i,
    input  logic [SIZE_W-1:0]   snp_req_size_i,
    input  logic [ADDR_W-1:0]   snp_req_addr_i,
    output logic                snp_req_ready_o,
    output logic                snp_out_val_o,
    output logic [FLIT_W-1:0]   snp_out_flit_o,
    input  logic                snp_out_crdt_i,
    output logic [CNT_W-1:0]    snp_crdt_cnt_o,
    output logic                snp_idle_o,
    output logic                snp_crdt_err_o
`ifdef SCR_L3_SNP_TX_PERF_EN
    ,
    output logic [31:0]         snp_stall_cnt_o
`endif
);

    localparam int PTR_W = $clog2(QUE_DEPTH);

    localparam logic [1:0] c_st_off   = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [FLIT_W-1:0] r_mem [QUE_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic [PTR_W:0]    w_wr_ptr_nxt;
    logic [PTR_W:0]    w_rd_ptr_nxt;
    logic              w_empty;
    logic              w_empty_nxt;
    logic              w_full;
    logic              w_push;
    logic              w_send;
    logic              w_active;
    logic [FLIT_W-1:0] w_flit_in;
    logic [CNT_W-1:0]  r_crdt_cnt;
    logic              r_crdt_err;
    logic              r_out_val;
    logic [FLIT_W-1:0] r_out_flit;
    logic              r_idle;

    // The extra wrap bit distinguishes full from empty when addresses match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // Ready depends only on registered state, never on the request valid.
    assign snp_req_ready_o = (r_state == c_st_run) && !w_full;
    assign w_push          = snp_req_val_i && snp_req_ready_o;
    assign w_active        = (r_state == c_st_run) || (r_state == c_st_drain);
    assign w_send          = !w_empty && (r_crdt_cnt != '0) && w_active;

    // Flit layout, LSB first: scrid, txnid, opc, size, addr.
    assign w_flit_in = {snp_req_addr_i, snp_req_size_i, snp_req_opc_i,
                        snp_req_txnid_i, snp_req_scrid_i};

    // Next-state logic for the enable/drain FSM; re-enable wins over drain-done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_off:   if (snp_tx_en_i) w_state_nxt = c_st_run;
            c_st_run:   if (!snp_tx_en_i) w_state_nxt = c_st_drain;
            c_st_drain: begin
                if (snp_tx_en_i)  w_state_nxt = c_st_run;
                else if (w_empty) w_state_nxt = c_st_off;
            end
            default:    w_state_nxt = c_st_off;
        endcase
    end

    // Next pointer values, used for pointer update and for the idle flag.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + {{PTR_W{1'b0}}, w_push};
        w_rd_ptr_nxt = r_rd_ptr + {{PTR_W{1'b0}}, w_send};
        w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    end

    // FSM, FIFO pointers, output flit register and idle flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_off;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_val  <= 1'b0;
            r_out_flit <= '0;
            r_idle     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_out_val <= w_send;
            if (w_send) begin
                r_out_flit <= r_mem[r_rd_ptr[PTR_W-1:0]];
            end
            r_idle    <= (w_state_nxt == c_st_off) && w_empty_nxt;
        end
    end

    // FIFO storage; contents need no reset since pointers guard them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_flit_in;
        end
    end

    // Credit counter: +1 per return pulse, -1 per send, saturating with a sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crdt_cnt <= '0;
            r_crdt_err <= 1'b0;
        end else if (snp_out_crdt_i && !w_send) begin
            if (r_crdt_cnt == CNT_W'(CRDT_MAX)) begin
                r_crdt_err <= 1'b1;
            end else begin
                r_crdt_cnt <= r_crdt_cnt + CNT_W'(1);
            end
        end else if (!snp_out_crdt_i && w_send) begin
            r_crdt_cnt <= r_crdt_cnt - CNT_W'(1);
        end
    end

    assign snp_out_val_o  = r_out_val;
    assign snp_out_flit_o = r_out_flit;
    assign snp_crdt_cnt_o = r_crdt_cnt;
    assign snp_crdt_err_o = r_crdt_err;
    assign snp_idle_o     = r_idle;

`ifdef SCR_L3_SNP_TX_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where work is queued but no credit is available.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!w_empty && (r_crdt_cnt == '0) && (r_state != c_st_off) &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign snp_stall_cnt_o = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scr_base_l3_bk_snp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr_base_l3_bk_snp_tx
// Brief    : Directed self-checking bench for the L3 bank snoop transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scr_base_l3_bk_snp_tx;

    localparam int FLIT_W = 59;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              req_val;
    logic [3:0]        req_scrid;
    logic [7:0]        req_txnid;
    logic [3:0]        req_opc;
    logic [2:0]        req_size;
    logic [39:0]       req_addr;
    logic              req_ready;
    logic              out_val;
    logic [FLIT_W-1:0] out_flit;
    logic              crdt;
    logic [3:0]        crdt_cnt;
    logic              idle;
    logic              crdt_err;
`ifdef SCR_L3_SNP_TX_PERF_EN
    logic [31:0]       stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    scr_base_l3_bk_snp_tx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .snp_tx_en_i     (en),
        .snp_req_val_i   (req_val),
        .snp_req_scrid_i (req_scrid),
        .snp_req_txnid_i (req_txnid),
        .snp_req_opc_i   (req_opc),
        .snp_req_size_i  (req_size),
        .snp_req_addr_i  (req_addr),
        .snp_req_ready_o (req_ready),
        .snp_out_val_o   (out_val),
        .snp_out_flit_o  (out_flit),
        .snp_out_crdt_i  (crdt),
        .snp_crdt_cnt_o  (crdt_cnt),
        .snp_idle_o      (idle),
        .snp_crdt_err_o  (crdt_err)
`ifdef SCR_L3_SNP_TX_PERF_EN
        ,
        .snp_stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; inputs set before a tick are sampled at it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en      = 1'b0;
        req_val = 1'b0;
        crdt    = 1'b0;
        tick();
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0h exp=0", req_ready); end
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL rst_val got=%0h exp=0", out_val); end
        checks++; if (out_flit !== '0) begin errors++; $display("FAIL rst_flit got=%0h exp=0", out_flit); end
        checks++; if (crdt_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", crdt_cnt); end
        checks++; if (crdt_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", crdt_err); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got=%0h exp=1", idle); end
    endtask

    task automatic test_basic_send();
        logic [FLIT_W-1:0] exp_flit;
        exp_flit = 59'h91A2B3C20315A2;
        en = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL run_ready got=%0h exp=1", req_ready); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL run_idle got=%0h exp=0", idle); end
        crdt = 1'b1;
        repeat (3) tick();
        crdt = 1'b0;
        checks++; if (crdt_cnt !== 4'd3) begin errors++; $display("FAIL cnt3 got=%0d exp=3", crdt_cnt); end
        req_val = 1'b1; req_scrid = 4'd2; req_txnid = 8'h5A; req_opc = 4'd1;
        req_size = 3'd3; req_addr = 40'h12_3456_7840;
        tick();
        req_val = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_val_n got=%0h exp=0", out_val); end
        tick();
        checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL basic_val_n1 got=%0h exp=1", out_val); end
        checks++; if (out_flit !== exp_flit) begin errors++; $display("FAIL basic_flit got=%0h exp=%0h", out_flit, exp_flit); end
        checks++; if (crdt_cnt !== 4'd2) begin errors++; $display("FAIL basic_cnt got=%0d exp=2", crdt_cnt); end
        tick();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%0h exp=0", out_val); end
        checks++; if (out_flit !== exp_flit) begin errors++; $display("FAIL basic_hold got=%0h exp=%0h", out_flit, exp_flit); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1;
        req_scrid = 4'd0; req_opc = 4'd0; req_size = 3'd0; req_addr = 40'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got=%0h exp=1", i, req_ready); end
            req_val = 1'b1; req_txnid = 8'h10 + 8'(i);
            tick();
        end
        req_val = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0h exp=0", req_ready); end
        tick();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL nocrdt_val got=%0h exp=0", out_val); end
        for (int i = 0; i < 4; i++) begin
            crdt = 1'b1;
            tick();
            checks++; if (crdt_cnt !== 4'd1) begin errors++; $display("FAIL b2b_cnt[%0d] got=%0d exp=1", i, crdt_cnt); end
            if (i == 0) begin
                checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL b2b_val0 got=%0h exp=0", out_val); end
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready0 got=%0h exp=0", req_ready); end
            end else begin
                checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL b2b_val[%0d] got=%0h exp=1", i, out_val); end
                checks++; if (out_flit[11:4] !== 8'h10 + 8'(i - 1)) begin errors++; $display("FAIL b2b_txn[%0d] got=%0h exp=%0h", i, out_flit[11:4], 8'h10 + 8'(i - 1)); end
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0h exp=1", i, req_ready); end
            end
        end
        crdt = 1'b0;
        tick();
        checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL b2b_val_last got=%0h exp=1", out_val); end
        checks++; if (out_flit[11:4] !== 8'h13) begin errors++; $display("FAIL b2b_txn_last got=%0h exp=13", out_flit[11:4]); end
        checks++; if (crdt_cnt !== 4'd0) begin errors++; $display("FAIL b2b_cnt_end got=%0d exp=0", crdt_cnt); end
        tick();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL b2b_quiet got=%0h exp=0", out_val); end
    endtask

    task automatic test_crdt_simul();
        req_val = 1'b1; req_txnid = 8'h20; tick();
        req_txnid = 8'h21; tick();
        req_val = 1'b0;
        crdt = 1'b1;
        tick();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL sim_same_cycle got=%0h exp=0", out_val); end
        checks++; if (crdt_cnt !== 4'd1) begin errors++; $display("FAIL sim_cnt1 got=%0d exp=1", crdt_cnt); end
        tick();
        crdt = 1'b0;
        checks++; if (crdt_cnt !== 4'd1) begin errors++; $display("FAIL sim_cnt_net got=%0d exp=1", crdt_cnt); end
        checks++; if (out_val !== 1'b1 || out_flit[11:4] !== 8'h20) begin errors++; $display("FAIL sim_flit0 got=%0h/%0h exp=1/20", out_val, out_flit[11:4]); end
        tick();
        checks++; if (out_val !== 1'b1 || out_flit[11:4] !== 8'h21) begin errors++; $display("FAIL sim_flit1 got=%0h/%0h exp=1/21", out_val, out_flit[11:4]); end
        checks++; if (crdt_cnt !== 4'd0) begin errors++; $display("FAIL sim_cnt0 got=%0d exp=0", crdt_cnt); end
    endtask

    task automatic test_overflow();
        crdt = 1'b1;
        repeat (8) tick();
        checks++; if (crdt_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt8 got=%0d exp=8", crdt_cnt); end
        checks++; if (crdt_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early got=%0h exp=0", crdt_err); end
        tick();
        crdt = 1'b0;
        checks++; if (crdt_err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%0h exp=1", crdt_err); end
        checks++; if (crdt_cnt !== 4'd8) begin errors++; $display("FAIL ovf_sat got=%0d exp=8", crdt_cnt); end
        tick();
        checks++; if (crdt_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0h exp=1", crdt_err); end
    endtask

    task automatic test_drain();
        do_reset();
        en = 1'b1;
        tick();
        req_val = 1'b1; req_txnid = 8'h30; tick();
        req_txnid = 8'h31; tick();
        req_val = 1'b0;
        en = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL drn_ready got=%0h exp=0", req_ready); end
        crdt = 1'b1;
        tick();
        checks++; if (out_val !== 1'b0 || crdt_cnt !== 4'd1) begin errors++; $display("FAIL drn_c1 got=%0h/%0d exp=0/1", out_val, crdt_cnt); end
        tick();
        crdt = 1'b0;
        checks++; if (out_val !== 1'b1 || out_flit[11:4] !== 8'h30) begin errors++; $display("FAIL drn_flit0 got=%0h/%0h exp=1/30", out_val, out_flit[11:4]); end
        tick();
        checks++; if (out_val !== 1'b1 || out_flit[11:4] !== 8'h31) begin errors++; $display("FAIL drn_flit1 got=%0h/%0h exp=1/31", out_val, out_flit[11:4]); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL drn_idle_early got=%0h exp=0", idle); end
        tick();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL drn_idle got=%0h exp=1", idle); end
        checks++; if (out_val !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL drn_off got=%0h/%0h exp=0/0", out_val, req_ready); end
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        tick();
        req_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_txnid = 8'h40 + 8'(i);
            tick();
        end
        req_val = 1'b0;
        crdt = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        crdt = 1'b0;
        checks++; if (crdt_cnt !== 4'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", crdt_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got=%0h exp=1", idle); end
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mid_val got=%0h exp=0", out_val); end
        tick();
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mid_val_next got=%0h exp=0", out_val); end
        crdt = 1'b1;
        tick();
        crdt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL mid_discard[%0d] got=%0h exp=0", i, out_val); end
        end
        checks++; if (crdt_cnt !== 4'd1) begin errors++; $display("FAIL mid_cnt_keep got=%0d exp=1", crdt_cnt); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; req_val = 1'b0; crdt = 1'b0;
        req_scrid = '0; req_txnid = '0; req_opc = '0; req_size = '0; req_addr = '0;
        tick();
        test_reset();
        test_basic_send();
        test_back_to_back();
        test_crdt_simul();
        test_overflow();
        test_drain();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
